// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM, one access in flight at a time.
// Optional ownership locking is compiled in with `define MEM_ARB_LOCK_EN.
module mem_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    cmd0,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam int         CW        = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {ARB, ACCESS, RESP} state_t;

    state_t     state, state_nxt;
    logic       owner, last_grant, grant, winner;
    logic [1:0] req, elig, win_cmd;

    assign req[0]  = (cmd0 == CMD_READ) || (cmd0 == CMD_WRITE);
    assign req[1]  = (cmd1 == CMD_READ) || (cmd1 == CMD_WRITE);
    assign win_cmd = winner ? cmd1 : cmd0;

`ifdef MEM_ARB_LOCK_EN
    logic          locked, own_lock, hold, release_lock, win_lock;
    logic [CW-1:0] lock_cnt, cnt_base;

    // A locked owner keeps the RAM while it requests or keeps lock high.
    assign own_lock     = owner ? lock1 : lock0;
    assign hold         = locked && (req[owner] || own_lock);
    assign release_lock = locked && !hold && (state == ARB);
    assign elig         = hold ? (req & (owner ? 2'b10 : 2'b01)) : req;
    assign win_lock     = winner ? lock1 : lock0;
    assign cnt_base     = (locked && (winner == owner)) ? lock_cnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
        end else if (grant) begin
            if (win_lock && (int'(cnt_base) + 1 < LOCK_MAX)) begin
                locked   <= 1'b1;
                lock_cnt <= cnt_base + 1'b1;
            end else begin
                locked   <= 1'b0;
                lock_cnt <= '0;
            end
        end else if (release_lock) begin
            locked   <= 1'b0;
            lock_cnt <= '0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
    assign elig        = req;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ARB;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        winner    = (elig == 2'b11) ? ~last_grant : elig[1];
        ack0      = 1'b0;
        ack1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata     = '0;
        case (state)
            ARB: begin
                if (|elig) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ack0      = ~owner;
                ack1      = owner;
                state_nxt = (mem_cmd == CMD_READ) ? RESP : ARB;
            end
            RESP: begin
                rvalid0   = ~owner;
                rvalid1   = owner;
                rdata     = mem_rdata;
                state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    // RAM command is live only for the single ACCESS cycle that follows a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_cmd    <= CMD_NONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            mem_cmd <= CMD_NONE;
            if (grant) begin
                mem_cmd    <= win_cmd;
                mem_addr   <= winner ? addr1 : addr0;
                mem_wdata  <= winner ? wdata1 : wdata0;
                owner      <= winner;
                last_grant <= winner;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, per-cycle transaction-level scoreboard, directed and random tests.
module tb_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    cmd0 = 2'b00, cmd1 = 2'b00;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cmd0(cmd0), .cmd1(cmd1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0), .lock1(lock1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed(int i);
        return 16'((i * 40503) ^ 16'h5A5A);
    endfunction

    // Single-port RAM: write on WRITE, read data one cycle after READ.
    logic [DW-1:0] ram [0:511];
    logic          ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 512; i++) ram[i] <= seed(i);
            ram_init <= 1'b1;
        end else if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_cmd == 2'b01) ? ram[mem_addr] : 16'h0;
    end

    int            n_vec = 0, n_err = 0, cyc = 0, next_free = 0, rv_cyc = 0;
    bit            last_g = 1'b1, rv_pend = 1'b0, rv_port = 1'b0, mon_en = 1'b1;
    logic [DW-1:0] rv_data;
    logic [DW-1:0] sh [0:511];

    // Advance one cycle; inputs are driven at negedge, outputs checked at the next negedge.
    // Reference: arbiter is free again 2 cycles after a write grant, 3 after a read grant;
    // a free arbiter grants the lone requester, or on a tie the port not granted last.
    task automatic step();
        bit v0, v1, w, gr;
        logic e_a0, e_a1, e_r0, e_r1;
        logic [1:0] e_cmd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (!mon_en) return;
        v0 = (cmd0 == 2'b01) || (cmd0 == 2'b10);
        v1 = (cmd1 == 2'b01) || (cmd1 == 2'b10);
        w = 1'b0; gr = 1'b0; e_cmd = 2'b00; e_addr = '0; e_wd = '0;
        e_r0 = rv_pend && (rv_cyc == cyc) && !rv_port;
        e_r1 = rv_pend && (rv_cyc == cyc) && rv_port;
        e_rd = rv_data;
        if (rv_pend && rv_cyc == cyc) rv_pend = 1'b0;
        if (reset) begin
            e_r0 = 1'b0; e_r1 = 1'b0; rv_pend = 1'b0; last_g = 1'b1; next_free = cyc + 1;
        end else if (cyc >= next_free && (v0 || v1)) begin
            gr = 1'b1;
            w = (v0 && v1) ? !last_g : v1;
            last_g = w;
            e_cmd = w ? cmd1 : cmd0; e_addr = w ? addr1 : addr0; e_wd = w ? wdata1 : wdata0;
            if (e_cmd == 2'b10) begin
                sh[e_addr] = e_wd; next_free = cyc + 2;
            end else begin
                rv_pend = 1'b1; rv_port = w; rv_data = sh[e_addr]; rv_cyc = cyc + 1; next_free = cyc + 3;
            end
        end
        e_a0 = gr && !w;
        e_a1 = gr && w;
        n_vec++; if (ack0 !== e_a0) begin n_err++; $display("FAIL sb_ack0 cyc %0d: got %b expected %b", cyc, ack0, e_a0); end
        n_vec++; if (ack1 !== e_a1) begin n_err++; $display("FAIL sb_ack1 cyc %0d: got %b expected %b", cyc, ack1, e_a1); end
        n_vec++; if (rvalid0 !== e_r0) begin n_err++; $display("FAIL sb_rvalid0 cyc %0d: got %b expected %b", cyc, rvalid0, e_r0); end
        n_vec++; if (rvalid1 !== e_r1) begin n_err++; $display("FAIL sb_rvalid1 cyc %0d: got %b expected %b", cyc, rvalid1, e_r1); end
        n_vec++; if (mem_cmd !== e_cmd) begin n_err++; $display("FAIL sb_mem_cmd cyc %0d: got %b expected %b", cyc, mem_cmd, e_cmd); end
        if (gr) begin
            n_vec++; if (mem_addr !== e_addr) begin n_err++; $display("FAIL sb_mem_addr cyc %0d: got %h expected %h", cyc, mem_addr, e_addr); end
            if (e_cmd == 2'b10) begin
                n_vec++; if (mem_wdata !== e_wd) begin n_err++; $display("FAIL sb_mem_wdata cyc %0d: got %h expected %h", cyc, mem_wdata, e_wd); end
            end
        end
        if (e_r0 || e_r1) begin
            n_vec++; if (rdata !== e_rd) begin n_err++; $display("FAIL sb_rdata cyc %0d: got %h expected %h", cyc, rdata, e_rd); end
        end
    endtask

    task automatic idle(int n);
        cmd0 = 2'b00; cmd1 = 2'b00; lock0 = 1'b0; lock1 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd0 = 2'b01; addr0 = 9'h020;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0) begin n_err++; $display("FAIL reset_handshake: got %b expected 0000", {ack0, ack1, rvalid0, rvalid1}); end
            n_vec++; if (mem_cmd !== 2'b00) begin n_err++; $display("FAIL reset_mem_cmd: got %b expected 00", mem_cmd); end
        end
        reset = 1'b0; cmd1 = 2'b01; addr1 = 9'h021;
        step();
        n_vec++; if ({ack0, ack1} !== 2'b10) begin n_err++; $display("FAIL reset_first_grant: got ack0/ack1 %b expected 10", {ack0, ack1}); end
        cmd0 = 2'b00;
        for (int i = 0; i < 4 && !ack1; i++) step();
        n_vec++; if (ack1 !== 1'b1) begin n_err++; $display("FAIL reset_second_grant: got ack1 %b expected 1", ack1); end
        idle(3);
    endtask

    task automatic test_write_read();
        int k;
        cmd0 = 2'b10; addr0 = 9'h010; wdata0 = 16'hBEEF;
        step();
        n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL wr_ack_latency: got ack0 %b expected 1", ack0); end
        cmd0 = 2'b01;
        k = 0;
        do begin step(); k++; end while (!ack0 && k < 6);
        n_vec++; if (k !== 2) begin n_err++; $display("FAIL rd_ack_spacing: got %0d cycles expected 2", k); end
        cmd0 = 2'b00;
        step();
        n_vec++; if ({rvalid0, rvalid1, ack0} !== 3'b100) begin n_err++; $display("FAIL rd_rvalid: got rvalid0/rvalid1/ack0 %b expected 100", {rvalid0, rvalid1, ack0}); end
        n_vec++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_data: got %h expected beef", rdata); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int got, prev_port, prev_cyc;
        got = 0; prev_port = -1; prev_cyc = 0;
        cmd0 = 2'b01; cmd1 = 2'b01;
        addr0 = 9'($urandom_range(0, 31)); addr1 = 9'($urandom_range(0, 31));
        for (int i = 0; i < 40 && got < 8; i++) begin
            step();
            if (ack0 || ack1) begin
                n_vec++; if (ack0 && ack1) begin n_err++; $display("FAIL b2b_dual_ack: got 11 expected one-hot"); end
                if (prev_port >= 0) begin
                    n_vec++; if (int'(ack1) == prev_port) begin n_err++; $display("FAIL b2b_alternate: got port %0d expected %0d", ack1, 1 - prev_port); end
                    n_vec++; if (cyc - prev_cyc !== 3) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 3", cyc - prev_cyc); end
                end
                prev_port = int'(ack1); prev_cyc = cyc; got++;
                if (ack0) addr0 = 9'($urandom_range(0, 31));
                else      addr1 = 9'($urandom_range(0, 31));
            end
        end
        n_vec++; if (got !== 8) begin n_err++; $display("FAIL b2b_timeout: got %0d grants expected 8", got); end
        idle(3);
    endtask

    task automatic test_reset_midflight();
        int k;
        cmd0 = 2'b01; addr0 = 9'h010;
        k = 0;
        do begin step(); k++; end while (!ack0 && k < 5);
        n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL mid_ack0: got %b expected 1", ack0); end
        reset = 1'b1; cmd0 = 2'b00;
        step();
        n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL mid_rvalid0_reset: got %b expected 0", rvalid0); end
        reset = 1'b0; cmd1 = 2'b01; addr1 = 9'h011;
        step();
        n_vec++; if ({ack1, rvalid0} !== 2'b10) begin n_err++; $display("FAIL mid_arb_after_reset: got ack1/rvalid0 %b expected 10", {ack1, rvalid0}); end
        cmd1 = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (rvalid0 !== 1'b0) begin n_err++; $display("FAIL mid_late_rvalid0: got %b expected 0", rvalid0); end
        end
    endtask

    task automatic test_random(int n);
        bit a0, a1;
        a0 = 1'b0; a1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (ack0) a0 = 1'b0;
            if (ack1) a1 = 1'b0;
            reset = ($urandom_range(0, 39) == 0);
            if (!a0) begin
                if ($urandom_range(0, 2) != 0) begin
                    a0 = 1'b1; cmd0 = 2'($urandom_range(1, 2));
                    addr0 = 9'($urandom_range(0, 15)); wdata0 = 16'($urandom);
                end else cmd0 = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            end
            if (!a1) begin
                if ($urandom_range(0, 2) != 0) begin
                    a1 = 1'b1; cmd1 = 2'($urandom_range(1, 2));
                    addr1 = 9'($urandom_range(0, 15)); wdata1 = 16'($urandom);
                end else cmd1 = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            end
            step();
        end
        reset = 1'b0;
        idle(4);
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock_max();
        int g;
        int grants [0:15];
        g = 0;
        reset = 1'b1; step(); reset = 1'b0;
        cmd1 = 2'b01; lock1 = 1'b1; addr1 = 9'h040;
        for (int i = 0; i < 60 && g < 9; i++) begin
            step();
            if (ack0 || ack1) begin
                grants[g] = int'(ack1); g++;
                if (ack1) begin addr1 = 9'($urandom_range(64, 127)); cmd0 = 2'b01; addr0 = 9'h050; end
                else cmd0 = 2'b00;
            end
        end
        n_vec++; if (g !== 9) begin n_err++; $display("FAIL lock_max_timeout: got %0d grants expected 9", g); end
        for (int i = 0; i < g; i++) begin
            n_vec++; if (grants[i] !== ((i < 8) ? 1 : 0)) begin n_err++; $display("FAIL lock_max_seq grant %0d: got port %0d expected %0d", i, grants[i], (i < 8) ? 1 : 0); end
        end
        idle(3);
    endtask

    task automatic test_lock_idle();
        int k;
        reset = 1'b1; step(); reset = 1'b0;
        cmd0 = 2'b10; lock0 = 1'b1; addr0 = 9'h060; wdata0 = 16'h1234;
        k = 0;
        do begin step(); k++; end while (!ack0 && k < 4);
        n_vec++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL lock_idle_ack0: got %b expected 1", ack0); end
        cmd0 = 2'b00; cmd1 = 2'b10; addr1 = 9'h061; wdata1 = 16'h5678;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL lock_idle_hold cycle %0d: got ack1 %b expected 0", i, ack1); end
        end
        lock0 = 1'b0;
        step();
        n_vec++; if (ack1 !== 1'b1) begin n_err++; $display("FAIL lock_idle_release: got ack1 %b expected 1", ack1); end
        idle(3);
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) sh[i] = seed(i);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reset_midflight();
        test_random(400);
`ifdef MEM_ARB_LOCK_EN
        mon_en = 1'b0;
        test_lock_max();
        test_lock_idle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
